// File: rtl/shift_arb_pkg.sv
// rtl/shift_arb_pkg.sv - shared types and constants for the shift arbiter
package shift_arb_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    MODE_SLL = 2'b00,
    MODE_SRA = 2'b01,
    MODE_ROR = 2'b10
  } shift_mode_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/shift_arb_shifter.sv
// rtl/shift_arb_shifter.sv - combinational 16-bit barrel shifter (SLL/SRA/ROR)
module shift_arb_shifter
  import shift_arb_pkg::*;
(
  input  logic [DATA_W-1:0] i_data,
  input  logic [3:0]        i_amt,
  input  logic [1:0]        i_mode,
  output logic [DATA_W-1:0] o_data
);

  always_comb begin
    o_data = i_data;
    case (i_mode)
      MODE_SLL: o_data = i_data << i_amt;
      MODE_SRA: o_data = $signed(i_data) >>> i_amt;
      // Rotate by shifting a doubled copy; mode 11 falls through to ROR.
      default:  o_data = DATA_W'({i_data, i_data} >> i_amt);
    endcase
  end

endmodule

// File: rtl/shift_arb.sv
// rtl/shift_arb.sv - two-requester round-robin arbiter in front of one shared shifter
module shift_arb
  import shift_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0][3:0]        req_amt,
  input  logic [NUM_REQ-1:0][1:0]        req_mode,
  input  logic                           flush,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [DATA_W-1:0]              rsp_data,
  output logic                           rsp_id
);

  arb_state_e        r_state;
  logic              r_ptr;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_id;

  logic              w_grant_idx;
  logic              w_slot_free;
  logic              w_xfer;
  logic [NUM_REQ-1:0] w_ready;
  logic [DATA_W-1:0] w_shift_data;

  // Pointer only breaks ties; a lone requester wins regardless of it.
  always_comb begin
    w_grant_idx = (req_valid[0] && req_valid[1]) ? r_ptr : req_valid[1];
    w_slot_free = rst_n && !flush && ((r_state == ST_EMPTY) || rsp_ready);
    w_ready     = '0;
    if (w_slot_free && (|req_valid)) begin
      w_ready[w_grant_idx] = 1'b1;
    end
  end

  assign w_xfer    = |w_ready;
  assign req_ready = w_ready;

  shift_arb_shifter u_shifter (
    .i_data (req_data[w_grant_idx]),
    .i_amt  (req_amt[w_grant_idx]),
    .i_mode (req_mode[w_grant_idx]),
    .o_data (w_shift_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= 1'b0;
      r_ptr       <= 1'b0;
    end else if (flush) begin
      r_state     <= ST_EMPTY;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_xfer) begin
            r_state     <= ST_FULL;
            r_rsp_valid <= 1'b1;
          end
        end
        ST_FULL: begin
          if (!w_xfer && rsp_ready) begin
            r_state     <= ST_EMPTY;
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_rsp_valid <= 1'b0;
        end
      endcase
      if (w_xfer) begin
        r_rsp_data <= w_shift_data;
        r_rsp_id   <= w_grant_idx;
        r_ptr      <= ~w_grant_idx;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_shift_arb.sv
// tb/tb_shift_arb.sv - directed self-checking bench for shift_arb
module tb_shift_arb;

  logic             clk;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][15:0] req_data;
  logic [1:0][3:0]  req_amt;
  logic [1:0][1:0]  req_mode;
  logic             flush;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [15:0]      rsp_data;
  logic             rsp_id;

  int checks;
  int failures;

  shift_arb #(.NUM_REQ(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .req_mode  (req_mode),
    .flush     (flush),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; flush = 1'b0; rsp_ready = 1'b0; req_valid = 2'b11;
    req_data = '0; req_amt = '0; req_mode = '0;
    step();
    step();
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      failures++;
      $display("FAIL reset_ready: got %b expected 00", req_ready);
    end
    rst_n = 1'b1; req_valid = 2'b00;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 16'h0000 || rsp_id !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got v=%b d=%h id=%b expected v=0 d=0000 id=0", rsp_valid, rsp_data, rsp_id);
    end
  endtask

  task automatic test_single();
    req_valid = 2'b01; req_data[0] = 16'h8000; req_amt[0] = 4'd4; req_mode[0] = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL single_ready: got %b expected 01", req_ready);
    end
    step();
    req_valid = 2'b00;
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'hF800 || rsp_id !== 1'b0) begin
      failures++;
      $display("FAIL single_rsp: got v=%b d=%h id=%b expected v=1 d=f800 id=0", rsp_valid, rsp_data, rsp_id);
    end
    rsp_ready = 1'b1;
    step();
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL consume_clear: got v=%b expected 0", rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_data [2];
    exp_data[0] = 16'h4123;
    exp_data[1] = 16'h8000;
    apply_reset();
    req_data[0] = 16'h1234; req_amt[0] = 4'd4;  req_mode[0] = 2'b10;
    req_data[1] = 16'h0001; req_amt[1] = 4'd15; req_mode[1] = 2'b00;
    req_valid = 2'b11; rsp_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (req_ready !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        failures++;
        $display("FAIL b2b_ready[%0d]: got %b expected %b", i, req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'(i % 2) || rsp_data !== exp_data[i % 2]) begin
        failures++;
        $display("FAIL b2b_rsp[%0d]: got v=%b id=%b d=%h expected v=1 id=%0d d=%h",
                 i, rsp_valid, rsp_id, rsp_data, i % 2, exp_data[i % 2]);
      end
    end
  endtask

  task automatic test_stall();
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (req_ready !== 2'b00) begin
        failures++;
        $display("FAIL stall_ready[%0d]: got %b expected 00", i, req_ready);
      end
      step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 16'h8000 || rsp_id !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got v=%b d=%h id=%b expected v=1 d=8000 id=1", i, rsp_valid, rsp_data, rsp_id);
      end
    end
  endtask

  task automatic test_flush();
    flush = 1'b1; rsp_ready = 1'b1; req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      failures++;
      $display("FAIL flush_ready: got %b expected 00", req_ready);
    end
    step();
    flush = 1'b0; rsp_ready = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_clear: got v=%b expected 0", rsp_valid);
    end
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL flush_ptr: got %b expected 01", req_ready);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 16'h4123) begin
      failures++;
      $display("FAIL flush_after: got v=%b id=%b d=%h expected v=1 id=0 d=4123", rsp_valid, rsp_id, rsp_data);
    end
  endtask

  task automatic test_reset_full();
    rst_n = 1'b0; req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      failures++;
      $display("FAIL rstfull_ready: got %b expected 00", req_ready);
    end
    step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 16'h0000 || rsp_id !== 1'b0) begin
      failures++;
      $display("FAIL rstfull_state: got v=%b d=%h id=%b expected v=0 d=0000 id=0", rsp_valid, rsp_data, rsp_id);
    end
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL rstfull_ptr: got %b expected 01", req_ready);
    end
    req_valid = 2'b00;
  endtask

  task automatic test_amt_zero();
    rsp_ready = 1'b1;
    req_valid = 2'b01; req_data[0] = 16'hA5A5; req_amt[0] = 4'd0;
    for (int m = 0; m < 4; m++) begin
      req_mode[0] = 2'(m);
      step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 16'hA5A5) begin
        failures++;
        $display("FAIL amt0_mode%0d: got v=%b d=%h expected v=1 d=a5a5", m, rsp_valid, rsp_data);
      end
    end
    req_valid = 2'b00;
    step();
  endtask

  task automatic test_modes_req1();
    logic [15:0] vd [4];
    logic [3:0]  va [4];
    logic [1:0]  vm [4];
    logic [15:0] ve [4];
    vd[0] = 16'h8001; va[0] = 4'd1; vm[0] = 2'b00; ve[0] = 16'h0002;
    vd[1] = 16'h8001; va[1] = 4'd1; vm[1] = 2'b01; ve[1] = 16'hC000;
    vd[2] = 16'h8001; va[2] = 4'd1; vm[2] = 2'b10; ve[2] = 16'hC000;
    vd[3] = 16'h1234; va[3] = 4'd8; vm[3] = 2'b11; ve[3] = 16'h3412;
    rsp_ready = 1'b1;
    req_valid = 2'b10;
    for (int i = 0; i < 4; i++) begin
      req_data[1] = vd[i]; req_amt[1] = va[i]; req_mode[1] = vm[i];
      #1;
      checks++;
      if (req_ready !== 2'b10) begin
        failures++;
        $display("FAIL req1_ready[%0d]: got %b expected 10", i, req_ready);
      end
      step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== ve[i]) begin
        failures++;
        $display("FAIL req1_rsp[%0d]: got v=%b id=%b d=%h expected v=1 id=1 d=%h", i, rsp_valid, rsp_id, rsp_data, ve[i]);
      end
    end
    req_valid = 2'b00;
    step();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_full();
    test_amt_zero();
    test_modes_req1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_arb.md
SHIFT_ARB -- requirements
Module: shift_arb

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 2, giving the number of requesters sharing one 16-bit shifter (fixed at 2 in this revision).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port req_valid, input, [1:0]: per-requester request valid.
REQ-005 The block SHALL have port req_ready, output, [1:0]: per-requester request accepted this cycle.
REQ-006 The block SHALL have port req_data, input, [1:0][15:0]: per-requester operand.
REQ-007 The block SHALL have port req_amt, input, [1:0][3:0]: per-requester shift amount, 0-15.
REQ-008 The block SHALL have port req_mode, input, [1:0][1:0]: per-requester mode; 00=SLL, 01=SRA, 1x=ROR.
REQ-009 The block SHALL have port flush, input, 1 bit: discards any held response.
REQ-010 The block SHALL have port rsp_valid, output, 1 bit: response valid.
REQ-011 The block SHALL have port rsp_ready, input, 1 bit: consumer accepts the response.
REQ-012 The block SHALL have port rsp_data, output, 16 bits: shift result.
REQ-013 The block SHALL have port rsp_id, output, 1 bit: index of the requester that owns rsp_data.

Function
REQ-014 The block SHALL accept a request only when the output slot is free: rsp_valid==0, or rsp_valid==1 and rsp_ready==1 in the same cycle.
REQ-015 The block SHALL assert at most one req_ready bit per cycle; req_ready[i] SHALL be combinational from req_valid, the priority pointer, the slot state and flush, and SHALL be 0 when req_valid[i]==0.
REQ-016 A transfer SHALL occur on requester i when req_valid[i] and req_ready[i] are both 1 at a clock edge.
REQ-017 When only one requester is valid, that requester SHALL be granted regardless of the pointer.
REQ-018 When both requesters are valid, the requester named by the 1-bit priority pointer SHALL be granted.
REQ-019 After every transfer the pointer SHALL point to the requester that was not granted.
REQ-020 The pointer SHALL NOT change in cycles without a transfer.
REQ-021 On a transfer in cycle N, rsp_valid SHALL be 1 in cycle N+1 (1-cycle latency), with rsp_data equal to the shift of the granted operand and rsp_id equal to the granted index.
REQ-022 The shift SHALL follow these rules: SLL fills with zeros; SRA fills with bit 15; ROR rotates right; amount 0 returns the operand unchanged; mode 11 behaves as 10.
REQ-023 rsp_data and rsp_id SHALL be registered and held stable while rsp_valid==1 and rsp_ready==0.
REQ-024 A simultaneous consume and transfer SHALL sustain one result per cycle; rsp_valid stays 1 and the new data is loaded.
REQ-025 A consume without a transfer SHALL clear rsp_valid on the next edge.
REQ-026 flush==1 SHALL force req_ready to 0 and clear rsp_valid on the next edge; flush has priority over rsp_ready and over new requests, and the pointer SHALL be unchanged.
REQ-027 The state machine SHALL have two states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-028 EMPTY SHALL go to FULL on a transfer.
REQ-029 FULL SHALL go to EMPTY on consume without a transfer, or on flush.
REQ-030 FULL SHALL remain FULL when stalled, or on a consume with a transfer.
REQ-031 The block SHALL guarantee no starvation: a continuously valid requester is granted within 2 transfers.

Reset
REQ-032 When rst_n==0 at a clock edge, the block SHALL go to state EMPTY with rsp_valid=0, rsp_data=16'h0000, rsp_id=0 and pointer=0.
REQ-033 While rst_n==0, req_ready SHALL be 2'b00.
REQ-034 Reset asserted while FULL SHALL discard the held response with no output handshake.

Structure
REQ-035 A shared package SHALL hold: the shift mode enum (SLL=2'b00, SRA=2'b01, ROR=2'b10), the arbiter state enum (EMPTY, FULL) and the constant DATA_W=16.
REQ-036 The block SHALL instantiate one combinational 16-bit barrel-shifter sub-module, Shifter, fed by the operand, amount and mode muxed from the granted requester.
REQ-037 The output register SHALL capture the Shifter output.

Verification
REQ-038 The bench SHALL cover: after reset, requester 0 only sends data=0x8000, amt=4, mode=01 -> rsp_valid one cycle later, rsp_data=0xF800, rsp_id=0.
REQ-039 The bench SHALL cover: both valid every cycle, rsp_ready held 1, operands 0x1234/amt 4/ROR and 0x0001/amt 15/SLL -> rsp_id alternates 0,1,0,1 starting at 0; data 0x4123, 0x8000; one response per cycle.
REQ-040 The bench SHALL cover: rsp_ready=0 for 3 cycles while FULL -> req_ready=00, and rsp_data/rsp_id held constant.
REQ-041 The bench SHALL cover: flush while FULL with req_valid=11 -> req_ready=00 that cycle, rsp_valid=0 next cycle, pointer unchanged.
REQ-042 The bench SHALL cover: rst_n=0 for one edge while FULL -> rsp_valid=0, rsp_data=0x0000, pointer=0 next cycle.
REQ-043 The bench SHALL cover: amt=0 with modes 00, 01, 10 and 11 on 0xA5A5 -> rsp_data=0xA5A5 each time.
